// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op encodings, FSM state type and iteration count for mult_div_unit
package mdu_pkg;
  localparam int ITER = 32;
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
endpackage

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: HI/LO unit bus; master drives start/op/rs_val/rt_val/mthi/mtlo/wr_data, slave drives busy/done/div_by_zero/hi/lo
interface mult_div_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wr_data;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master (
    output start, op, rs_val, rt_val, mthi, mtlo, wr_data,
    input  busy, done, div_by_zero, hi, lo
  );
  modport slave (
    input  start, op, rs_val, rt_val, mthi, mtlo, wr_data,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mdu_step.sv
// mdu_step: one combinational shift-add (multiply) or restoring (divide) step; i_acc/i_opd/i_div in, o_acc next accumulator, o_q quotient bit
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_opd,
  input  logic               i_div,
  output logic [2*WIDTH-1:0] o_acc,
  output logic               o_q
);
  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_part;
  logic [WIDTH:0] w_trial;
  logic           w_ge;
  always_comb begin
    w_sum   = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_opd} : '0);
    w_part  = i_acc[2*WIDTH-1:WIDTH-1];
    w_trial = w_part - {1'b0, i_opd};
    w_ge    = ~w_trial[WIDTH];
    o_q     = i_div & w_ge;
    o_acc   = i_div ? {(w_ge ? w_trial[WIDTH-1:0] : w_part[WIDTH-1:0]), i_acc[WIDTH-2:0], 1'b0}
                    : {w_sum, i_acc[WIDTH-1:1]};
  end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU into HI/LO; clk, rst_n (sync active-low), bus slave (start/op/rs_val/rt_val/mthi/mtlo/wr_data in, busy/done/div_by_zero/hi/lo out)
module mult_div_unit import mdu_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int ITER  = mdu_pkg::ITER
) (
  input logic            clk,
  input logic            rst_n,
  mult_div_unit_if.slave bus
);
  localparam int CW = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);
  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] w_acc;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   r_opd;
  logic [WIDTH-1:0]   r_rs;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic               r_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_dz;
  logic               r_busy;
  logic               r_done;
  logic               r_dbz;
  logic               w_q;
  logic               w_div;
  logic               w_sgn;
  logic               w_sa;
  logic               w_sb;
  assign w_div  = bus.op == OP_DIV || bus.op == OP_DIVU;
  assign w_sgn  = bus.op == OP_MULT || bus.op == OP_DIV;
  assign w_sa   = w_sgn & bus.rs_val[WIDTH-1];
  assign w_sb   = w_sgn & bus.rt_val[WIDTH-1];
  assign w_a    = w_sa ? -bus.rs_val : bus.rs_val;
  assign w_b    = w_sb ? -bus.rt_val : bus.rt_val;
  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quo  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
  mdu_step #(.WIDTH(WIDTH)) u_step (
    .i_acc (r_acc),
    .i_opd (r_opd),
    .i_div (r_div),
    .o_acc (w_acc),
    .o_q   (w_q)
  );
  always_ff @(posedge clk) begin
    r_done <= 1'b0;
    if (!rst_n) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_dbz   <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state <= CALC;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_div   <= w_div;
            r_neg_q <= w_sa ^ w_sb;
            r_neg_r <= w_sa;
            r_dz    <= w_div && bus.rt_val == '0;
            r_rs    <= bus.rs_val;
            r_opd   <= w_div ? w_b : w_a;
            r_acc   <= {{WIDTH{1'b0}}, (w_div ? w_a : w_b)};
          end else begin
            if (bus.mthi) r_hi <= bus.wr_data;
            if (bus.mtlo) r_lo <= bus.wr_data;
          end
        end
        CALC: begin
          r_acc <= w_acc | (2*WIDTH)'(w_q);
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) r_state <= FIX;
        end
        FIX: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_dbz   <= r_dz;
          r_hi    <= r_dz ? r_rs : r_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
          r_lo    <= r_dz ? '1 : r_div ? w_quo : w_prod[WIDTH-1:0];
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dbz;
  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: randomized scoreboard bench for mult_div_unit against an arithmetic reference model
module tb_mult_div_unit;
  import mdu_pkg::*;
  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          t;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errs = 0;
  int cyc = 0;
  logic [31:0] old_hi;
  exp_t exp_q[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  mult_div_unit_if bus();
  mult_div_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint sa;
    longint sb;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    e.dz = 1'b0;
    e.t = 0;
    if ((o == OP_DIV || o == OP_DIVU) && b == 32'd0) begin
      e.hi = a;
      e.lo = 32'hFFFF_FFFF;
      e.dz = 1'b1;
    end else if (o == OP_MULT) begin
      p = 64'(sa * sb);
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (o == OP_MULTU) begin
      p = ua * ub;
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (o == OP_DIV) begin
      e.lo = 32'(sa / sb);
      e.hi = 32'(sa % sb);
    end else begin
      e.lo = 32'(ua / ub);
      e.hi = 32'(ua % ub);
    end
    return e;
  endfunction
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 300));
      default: return 32'($urandom);
    endcase
  endfunction
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e = model(o, a, b);
    e.t = cyc + 1;
    exp_q.push_back(e);
    bus.start = 1'b1;
    bus.op = o;
    bus.rs_val = a;
    bus.rt_val = b;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_start", 32'(bus.busy), 32'd1);
  endtask
  task automatic wait_done();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.done) return;
    end
    checks++;
    errs++;
    $display("FAIL done_timeout: no done within 60 cycles, expected one");
  endtask
  task automatic mt(input logic h, input logic l, input logic [31:0] d);
    logic [31:0] eh;
    logic [31:0] el;
    eh = h ? d : bus.hi;
    el = l ? d : bus.lo;
    bus.mthi = h;
    bus.mtlo = l;
    bus.wr_data = d;
    @(negedge clk);
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    chk("mt_hi", bus.hi, eh);
    chk("mt_lo", bus.lo, el);
  endtask
  task automatic noise(input logic [31:0] d);
    repeat ($urandom_range(1, 20)) @(negedge clk);
    bus.start = 1'b1;
    bus.op = 2'($urandom);
    bus.rs_val = 32'($urandom);
    bus.rt_val = 32'($urandom);
    bus.mthi = 1'b1;
    bus.mtlo = 1'b1;
    bus.wr_data = d;
    @(negedge clk);
    bus.start = 1'b0;
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
  endtask
  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_done: got done=1, expected 0");
      end else begin
        e = exp_q.pop_front();
        chk("result_hi", bus.hi, e.hi);
        chk("result_lo", bus.lo, e.lo);
        chk("div_by_zero", 32'(bus.div_by_zero), 32'(e.dz));
        chk("latency_edges", 32'(cyc - e.t), 32'd33);
        chk("busy_at_done", 32'(bus.busy), 32'd0);
      end
    end
  end
  initial begin
    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.rs_val = '0;
    bus.rt_val = '0;
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    bus.wr_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_hi", bus.hi, 32'd0);
    chk("reset_lo", bus.lo, 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_dbz", 32'(bus.div_by_zero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    wait_done();
    chk("mult_neg3x7_hi", bus.hi, 32'hFFFF_FFFF);
    chk("mult_neg3x7_lo", bus.lo, 32'hFFFF_FFEB);
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done();
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done();
    chk("div_neg7by2_lo", bus.lo, 32'hFFFF_FFFD);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done();
    issue(OP_DIVU, 32'd100, 32'd0);
    wait_done();
    chk("divu_by_zero_flag", 32'(bus.div_by_zero), 32'd1);
    issue(OP_MULTU, 32'd2, 32'd3);
    wait_done();
    issue(OP_MULTU, 32'd5, 32'd5);
    repeat (5) @(negedge clk);
    bus.start = 1'b1;
    bus.op = OP_MULT;
    bus.rs_val = 32'd9;
    bus.rt_val = 32'd9;
    bus.mtlo = 1'b1;
    bus.wr_data = 32'hDEAD;
    @(negedge clk);
    bus.start = 1'b0;
    bus.mtlo = 1'b0;
    chk("mtlo_ignored_busy", bus.lo, 32'd6);
    wait_done();
    chk("multu_5x5_lo", bus.lo, 32'd25);
    mt(1'b1, 1'b0, 32'h1234);
    mt(1'b0, 1'b1, 32'h5678);
    mt(1'b1, 1'b1, 32'hCAFE_F00D);
    old_hi = bus.hi;
    bus.mthi = 1'b1;
    bus.wr_data = 32'hBAD0;
    issue(OP_DIVU, 32'd1000, 32'd7);
    bus.mthi = 1'b0;
    chk("start_beats_mthi", bus.hi, old_hi);
    wait_done();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) mt(1'($urandom), 1'($urandom), 32'($urandom));
      issue(2'($urandom), pick(), pick());
      if ($urandom_range(0, 1) == 1) noise(32'($urandom));
      wait_done();
    end
    issue(OP_DIVU, 32'($urandom), 32'($urandom_range(1, 1000)));
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("abort_hi", bus.hi, 32'd0);
    chk("abort_lo", bus.lo, 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_dbz", 32'(bus.div_by_zero), 32'd0);
    rst_n = 1'b1;
    repeat (45) @(negedge clk);
    chk("abort_no_result", bus.lo, 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit for the MIPS datapath's HI/LO path. It executes MULT, MULTU, DIV and DIVU on two 32-bit register operands over a fixed multi-cycle sequence and holds the results in architectural HI and LO registers. `hi` and `lo` drive the HI/LO inputs of the 32-bit 4:1 writeback-select mux, which is selected by MFHI/MFLO. `busy` feeds the hazard logic so that it stalls dependent instructions.

## Interface

Parameters
- `WIDTH`, default 32: operand and HI/LO width. Only 32 is supported.
- `ITER`, default 32: iteration count. Must equal `WIDTH`.

Ports
- `clk`, in, 1: single clock; every state element updates on the rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `start`, in, 1: launch operation; sampled only in IDLE.
- `op`, in, 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `rs_val`, in, 32: multiplicand / dividend.
- `rt_val`, in, 32: multiplier / divisor.
- `mthi`, in, 1: write `wr_data` to HI (MTHI).
- `mtlo`, in, 1: write `wr_data` to LO (MTLO).
- `wr_data`, in, 32: MTHI/MTLO data.
- `busy`, out, 1: operation in flight.
- `done`, out, 1: one-cycle pulse; HI/LO hold the new result.
- `div_by_zero`, out, 1: sticky flag for the last completed op; set when a DIV/DIVU had `rt_val`=0.
- `hi`, out, 32: HI register.
- `lo`, out, 32: LO register.

## Operation

- FSM states:
  - IDLE: `start`=1 → CALC.
  - CALC: stays for exactly ITER cycles, then → FIX.
  - FIX: one cycle, then → IDLE.
- In IDLE with `start`=1:
  - Latch `op` and the operand magnitudes; signed ops take |x| and record the result signs.
  - Clear the iteration counter.
- CALC, multiply: one shift-add step per cycle on a 64-bit accumulator.
- CALC, divide: one restoring step per cycle: 33-bit trial subtract, shift in the quotient bit.
- FIX:
  - Apply sign correction: the product is negated if the operand signs differ.
  - Quotient truncates toward zero; the remainder takes the dividend's sign.
  - Write HI and LO. Multiply: HI=product[63:32], LO=product[31:0]. Divide: HI=remainder, LO=quotient.
- Divide by zero:
  - The iterations still run.
  - Result is forced to HI=`rs_val`, LO=32'hFFFF_FFFF, and `div_by_zero`=1.
  - Any other completed op clears `div_by_zero`.
- DIV 0x8000_0000 / -1: LO=0x8000_0000, HI=0. No flag.
- `start` while busy is ignored, and the captured operands are unaffected.
- `mthi`/`mtlo` in IDLE:
  - HI/LO take `wr_data` at the next edge.
  - If asserted together with `start`, `start` wins and the writes are dropped.
  - Ignored while busy.
  - `mthi` and `mtlo` together write both registers.
- Reset (`rst_n`=0 at an edge):
  - `hi`=0, `lo`=0, `busy`=0, `done`=0, `div_by_zero`=0, FSM=IDLE.
  - An operation in progress is aborted with no partial HI/LO update.

## Timing

- `start` sampled at edge E0 → `busy`=1 from E0 through E0+33.
- FIX writes HI/LO at edge E0+33. `done`=1 and the new `hi`/`lo` are visible during the cycle after E0+33.
- `busy`=0 while `done`=1.
- Total latency from start edge to result visible: 34 cycles.
- A new `start` is accepted in the same cycle that `done`=1, giving back-to-back ops every 34 cycles.
- `hi`/`lo` are registered outputs and are stable except at a FIX or MTHI/MTLO edge.

## Structure

- Shared package `mdu_pkg`:
  - Op encodings `OP_MULT`, `OP_MULTU`, `OP_DIV`, `OP_DIVU`.
  - State enum `IDLE`/`CALC`/`FIX`.
  - `ITER` constant.
- Sub-module `mdu_step`: combinational single iteration. Inputs are the accumulator/remainder, operand and mode; outputs are the next accumulator and the quotient bit. Instantiated once.
- Top contains the FSM, counter, sign capture/correction and the HI/LO registers.

## Test plan

- Reset then MULT `rs`=0xFFFF_FFFD (-3), `rt`=7 → `done` 34 cycles after start; HI=0xFFFF_FFFF, LO=0xFFFF_FFEB.
- MULTU 0xFFFF_FFFF × 0xFFFF_FFFF → HI=0xFFFF_FFFE, LO=0x0000_0001.
- DIV -7 / 2 → LO=0xFFFF_FFFD, HI=0xFFFF_FFFF. DIV 0x8000_0000 / -1 → LO=0x8000_0000, HI=0.
- DIVU 100 / 0 → HI=100, LO=0xFFFF_FFFF, `div_by_zero`=1. Next MULTU 2×3 → HI=0, LO=6, flag cleared.
- Start MULTU 5×5, pulse `start` (MULT 9×9) and `mtlo` (0xDEAD) mid-op → both ignored; LO=25. Then `mthi`=0x1234 in IDLE → HI=0x1234 next cycle.
- Start DIVU, drive `rst_n`=0 at cycle 10 → all outputs 0, FSM IDLE; no later `done`.
